// File: rtl/sound_sequencer_if.sv
// Request/status bundle between the game controller and the jingle sequencer.
// The controller side uses the master modport; the sequencer uses the slave modport.
interface sound_sequencer_if #(
    parameter int FREQ_W = 10
);
    logic              win_pulse;
    logic              lose_pulse;
    logic              mute;
    logic [FREQ_W-1:0] sound_freq;
    logic              enable_sound;
    logic              busy;
    logic              done;

    modport master (
        output win_pulse,
        output lose_pulse,
        output mute,
        input  sound_freq,
        input  enable_sound,
        input  busy,
        input  done
    );

    modport slave (
        input  win_pulse,
        input  lose_pulse,
        input  mute,
        output sound_freq,
        output enable_sound,
        output busy,
        output done
    );
endinterface

// File: rtl/sound_sequencer.sv
// Win/lose jingle player: steps a fixed note table with note and gap timing.
// Define SOUND_PREEMPT_EN to let a new request abort a running jingle.
module sound_sequencer #(
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 2_500_000,
    parameter int FREQ_W     = 10
) (
    input  logic                clk,
    input  logic                reset,
    sound_sequencer_if.slave    bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NOTE = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    logic [1:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic              jingle_q, jingle_d;
    logic [CNT_W-1:0]  tick_q, tick_d;
    logic [FREQ_W-1:0] sound_freq_q, sound_freq_d;
    logic              enable_q, enable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              req_s;
    logic              completing_s;
    logic              start_s;
    logic [1:0]        last_idx_s;

    // jingle_q: 1 selects the lose table, 0 the win table
    function automatic logic [FREQ_W-1:0] note_code(input logic lose, input logic [1:0] idx);
        logic [9:0] code;
        code = 10'd0;
        if (lose) begin
            case (idx)
                2'd0:    code = 10'd392;
                2'd1:    code = 10'd330;
                2'd2:    code = 10'd262;
                default: code = 10'd0;
            endcase
        end else begin
            case (idx)
                2'd0:    code = 10'd262;
                2'd1:    code = 10'd330;
                2'd2:    code = 10'd392;
                2'd3:    code = 10'd523;
                default: code = 10'd0;
            endcase
        end
        return FREQ_W'(code);
    endfunction

    // Request decode and acceptance; a request on the completing edge is always taken
    always_comb begin
        req_s        = bus.win_pulse | bus.lose_pulse;
        last_idx_s   = jingle_q ? 2'd2 : 2'd3;
        completing_s = (state_q == S_NOTE) && (tick_q == NOTE_LAST) && (idx_q == last_idx_s);
`ifdef SOUND_PREEMPT_EN
        start_s      = req_s;
`else
        start_s      = req_s && ((state_q == S_IDLE) || completing_s);
`endif
    end

    // Next-state, counters and registered-output values
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        jingle_d = jingle_q;
        tick_d   = tick_q;
        done_d   = completing_s;
        if (start_s) begin
            state_d  = S_NOTE;
            idx_d    = 2'd0;
            jingle_d = bus.lose_pulse;
            tick_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    tick_d = {CNT_W{1'b0}};
                end
                S_NOTE: begin
                    if (tick_q == NOTE_LAST) begin
                        tick_d = {CNT_W{1'b0}};
                        if (completing_s) begin
                            state_d = S_IDLE;
                            idx_d   = 2'd0;
                        end else if (GAP_TICKS == 0) begin
                            idx_d = idx_q + 2'd1;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        tick_d = tick_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (tick_q == GAP_LAST) begin
                        state_d = S_NOTE;
                        idx_d   = idx_q + 2'd1;
                        tick_d  = {CNT_W{1'b0}};
                    end else begin
                        tick_d = tick_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    tick_d  = {CNT_W{1'b0}};
                end
            endcase
        end
        // GAP keeps the index of the note just played, so the code holds there
        sound_freq_d = (state_d == S_IDLE) ? {FREQ_W{1'b0}} : note_code(jingle_d, idx_d);
        enable_d     = (state_d == S_NOTE) && !bus.mute;
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            jingle_q     <= 1'b0;
            tick_q       <= {CNT_W{1'b0}};
            sound_freq_q <= {FREQ_W{1'b0}};
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            jingle_q     <= jingle_d;
            tick_q       <= tick_d;
            sound_freq_q <= sound_freq_d;
            enable_q     <= enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.sound_freq   = sound_freq_q;
    assign bus.enable_sound = enable_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: directed scenarios plus random requests, checked
// each cycle against a timeline model built from the note tables.
module tb_sound_sequencer;
    localparam int NOTE_TICKS = 4;
    localparam int GAP_TICKS  = 2;
    localparam int FREQ_W     = 10;

    logic clk;
    logic reset;
    sound_sequencer_if #(.FREQ_W(FREQ_W)) sif ();

    sound_sequencer #(
        .NOTE_TICKS (NOTE_TICKS),
        .GAP_TICKS  (GAP_TICKS),
        .FREQ_W     (FREQ_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_failed;

    int win_t[4]  = '{262, 330, 392, 523};
    int lose_t[3] = '{392, 330, 262};

    // Model: queue of per-cycle outputs still to be shown for the active jingle
    int q_freq[$];
    bit q_snd[$];
    int m_freq;
    bit m_en, m_busy, m_done;

    int busy_cnt, done_cnt, en_cnt;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic build(input bit lose);
        int n;
        int f;
        n = lose ? 3 : 4;
        for (int i = 0; i < n; i++) begin
            f = lose ? lose_t[i] : win_t[i];
            for (int k = 0; k < NOTE_TICKS; k++) begin
                q_freq.push_back(f);
                q_snd.push_back(1'b1);
            end
            if (i < n - 1) begin
                for (int k = 0; k < GAP_TICKS; k++) begin
                    q_freq.push_back(f);
                    q_snd.push_back(1'b0);
                end
            end
        end
    endtask

    task automatic model_step(input bit r, input bit w, input bit l, input bit m);
        bit completing;
        bit accept;
        if (r) begin
            q_freq.delete();
            q_snd.delete();
            m_freq = 0; m_en = 0; m_busy = 0; m_done = 0;
        end else begin
            completing = m_busy && (q_freq.size() == 0);
`ifdef SOUND_PREEMPT_EN
            accept = w || l;
`else
            accept = (w || l) && (!m_busy || completing);
`endif
            if (accept) begin
                q_freq.delete();
                q_snd.delete();
                build(l);
            end
            m_done = completing;
            if (q_freq.size() > 0) begin
                m_freq = q_freq.pop_front();
                m_en   = q_snd.pop_front() && !m;
                m_busy = 1'b1;
            end else begin
                m_freq = 0; m_en = 0; m_busy = 0;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit w, input bit l, input bit m);
        reset = r;
        sif.win_pulse  = w;
        sif.lose_pulse = l;
        sif.mute       = m;
        @(posedge clk);
        model_step(r, w, l, m);
        @(negedge clk);
        check_eq("freq",   int'(sif.sound_freq),   m_freq);
        check_eq("enable", int'(sif.enable_sound), int'(m_en));
        check_eq("busy",   int'(sif.busy),         int'(m_busy));
        check_eq("done",   int'(sif.done),         int'(m_done));
        busy_cnt += int'(sif.busy);
        done_cnt += int'(sif.done);
        en_cnt   += int'(sif.enable_sound);
    endtask

    task automatic clear_counts();
        busy_cnt = 0; done_cnt = 0; en_cnt = 0;
    endtask

    task automatic idle(input int n, input bit m);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, m);
    endtask

    initial begin
        bit r, w, l, m;
        n_tests = 0; n_failed = 0;
        m_freq = 0; m_en = 0; m_busy = 0; m_done = 0;
        reset = 1'b1;
        sif.win_pulse = 1'b0; sif.lose_pulse = 1'b0; sif.mute = 1'b0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rst_freq", int'(sif.sound_freq), 0);
        check_eq("rst_busy", int'(sif.busy), 0);

        // Lose jingle from idle: 16 busy cycles, one done, then silence
        clear_counts();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("lose_first", int'(sif.sound_freq), 392);
        idle(20, 1'b0);
        check_eq("lose_busy", busy_cnt, 16);
        check_eq("lose_done", done_cnt, 1);
        check_eq("lose_en", en_cnt, 12);

        // Simultaneous requests: lose takes priority
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("both_first", int'(sif.sound_freq), 392);
        idle(20, 1'b0);

        // Muted win jingle: sequence runs, enable stays low
        clear_counts();
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(25, 1'b1);
        check_eq("mute_busy", busy_cnt, 22);
        check_eq("mute_done", done_cnt, 1);
        check_eq("mute_en", en_cnt, 0);

        // Lose request during the second win note
        clear_counts();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(7, 1'b0);
        check_eq("win_note2", int'(sif.sound_freq), 330);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SOUND_PREEMPT_EN
        check_eq("preempt_freq", int'(sif.sound_freq), 392);
`else
        check_eq("ignore_freq", int'(sif.sound_freq), 330);
`endif
        idle(30, 1'b0);
        check_eq("overlap_done", done_cnt, 1);

        // Reset in the gap of a lose jingle
        clear_counts();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b0);
        check_eq("gap_en", int'(sif.enable_sound), 0);
        check_eq("gap_freq", int'(sif.sound_freq), 392);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rst_mid_busy", int'(sif.busy), 0);
        idle(3, 1'b0);
        check_eq("rst_mid_done", done_cnt, 0);
        clear_counts();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(25, 1'b0);
        check_eq("after_rst_busy", busy_cnt, 22);

        // Win requested on the edge that completes a lose jingle
        clear_counts();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(15, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("chain_done", int'(sif.done), 1);
        check_eq("chain_freq", int'(sif.sound_freq), 262);
        check_eq("chain_en", int'(sif.enable_sound), 1);
        idle(25, 1'b0);
        check_eq("chain_busy", busy_cnt, 16 + 22);
        check_eq("chain_dones", done_cnt, 2);

        // Random traffic against the model
        m = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 24) == 0);
            l = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 15) == 0) m = ~m;
            cycle(r, w, l, m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
